// File: rtl/lz_restore_shifter.sv
// lz_restore_shifter: multi-cycle left shifter that undoes a leading-zero count.
// The shift runs binary-weighted, one stage per cycle, with the largest weight first.
// A finished result is held, with valid/ready handshaking, until the consumer takes it.
module lz_restore_shifter #(
   parameter int DATAWIDTH = 32,
   parameter int WIDTH     = $clog2(DATAWIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic [WIDTH:0]       in_cnt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 out_norm,
   output logic                 out_ovf
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [WIDTH:0]   FULL_CNT  = (WIDTH+1)'(DATAWIDTH);
   localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(WIDTH-1);

   state_t               state, state_nxt;
   logic [DATAWIDTH-1:0] data;
   logic [WIDTH:0]       cnt;
   logic [WIDTH-1:0]     step;
   logic                 ovf;
   logic [DATAWIDTH-1:0] res_data;
   logic                 res_norm, res_ovf, res_vld;
   logic                 accept, publish, handoff;

   // One binary-weighted stage: shift by 2**s when that count bit is set.
   function automatic logic [DATAWIDTH-1:0] stage_shift(
      input logic [DATAWIDTH-1:0] d,
      input logic [WIDTH-1:0]     s
   );
      stage_shift = d << (32'd1 << s);
   endfunction

   assign out_valid = res_vld;
   assign out_data  = res_data;
   assign out_norm  = res_norm;
   assign out_ovf   = res_ovf;

   // State register; reset abandons any shift in flight or pending result.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake decode. DONE spends its first cycle latching the
   // result into the output registers, then waits for the consumer.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      publish   = 1'b0;
      handoff   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (step == '0) state_nxt = DONE;
         end
         DONE: begin
            if (!res_vld) begin
               publish = 1'b1;
            end else if (out_ready) begin
               handoff   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result-valid flag: raised when the result is latched, dropped on handshake.
   always_ff @(posedge clk) begin
      if (rst)          res_vld <= 1'b0;
      else if (publish) res_vld <= 1'b1;
      else if (handoff) res_vld <= 1'b0;
   end

   // Output registers; they keep the last result until the next one is latched.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_data <= '0;
         res_norm <= 1'b0;
         res_ovf  <= 1'b0;
      end else if (publish) begin
         res_data <= data;
         res_norm <= data[DATAWIDTH-1];
         res_ovf  <= ovf;
      end
   end

   // Working datapath: capture on accept (a count of DATAWIDTH or more clears the
   // word), then one weighted stage per SHIFT cycle from the top step down.
   always_ff @(posedge clk) begin
      if (accept) begin
         data <= in_cnt[WIDTH] ? '0 : in_data;
         cnt  <= in_cnt;
         ovf  <= (in_cnt > FULL_CNT);
         step <= LAST_STEP;
      end else if (state == SHIFT) begin
         if (cnt[step]) data <= stage_shift(data, step);
         step <= step - 1'b1;
      end
   end

endmodule
